// File: rtl/sseg_scan_driver_pkg.sv
// rtl/sseg_scan_driver_pkg.sv - shared constants and helpers for the 8-digit seven-segment scan driver
package sseg_scan_driver_pkg;

    localparam int DEFAULT_CLK_DIV = 100000;
    localparam int NUM_DIGITS      = 8;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [7:0] AN_OFF  = 8'hFF;

    // Active-low glyphs, bit order {g,f,e,d,c,b,a}; 10-15 render as A b C d E F
    localparam logic [6:0] HEX_GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic logic [7:0] anode_select_n(input logic [2:0] idx);
        return ~(8'h01 << idx);
    endfunction

endpackage

// File: rtl/sseg_scan_driver_hex_to_sseg.sv
// rtl/sseg_scan_driver_hex_to_sseg.sv - combinational hex nibble to active-low seven-segment glyph
module hex_to_sseg
    import sseg_scan_driver_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = HEX_GLYPH[nibble];
    end

endmodule

// File: rtl/sseg_scan_driver.sv
// rtl/sseg_scan_driver.sv - time-multiplexed 8-digit hex display driver with tear-free double buffering
module sseg_scan_driver
    import sseg_scan_driver_pkg::*;
#(
    parameter int CLK_DIV = DEFAULT_CLK_DIV,
    parameter int CNT_W   = 17
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        en,
    input  logic        load,
    input  logic [31:0] data_in,
    input  logic [7:0]  dp_in,
    input  logic [7:0]  blank_in,
    output logic [7:0]  AN,
    output logic [6:0]  s,
    output logic        DP,
    output logic [2:0]  digit_idx,
    output logic        frame_done
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt;
    logic             en_q;

    logic [31:0] shadow_data;
    logic [7:0]  shadow_dp;
    logic [7:0]  shadow_blank;
    logic [31:0] active_data;
    logic [7:0]  active_dp;
    logic [7:0]  active_blank;

    logic [31:0] next_data;
    logic [7:0]  next_dp;
    logic [7:0]  next_blank;

    logic        slot_end;
    logic        frame_wrap;
    logic        en_rise;
    logic        digit_on;
    logic [3:0]  cur_nibble;
    logic [6:0]  cur_glyph;

    assign slot_end   = (cnt == CNT_LAST);
    assign frame_wrap = en && slot_end && (digit_idx == 3'd7);
    assign en_rise    = en && !en_q;
    assign frame_done = frame_wrap;

    // A load on the same edge as an active update bypasses straight into the active set
    assign next_data  = load ? data_in  : shadow_data;
    assign next_dp    = load ? dp_in    : shadow_dp;
    assign next_blank = load ? blank_in : shadow_blank;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt       <= '0;
            digit_idx <= 3'd0;
        end else if (en) begin
            if (slot_end) begin
                cnt       <= '0;
                digit_idx <= digit_idx + 3'd1;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            en_q         <= 1'b0;
            shadow_data  <= '0;
            shadow_dp    <= '0;
            shadow_blank <= '1;
            active_data  <= '0;
            active_dp    <= '0;
            active_blank <= '1;
        end else begin
            en_q <= en;
            if (load) begin
                shadow_data  <= data_in;
                shadow_dp    <= dp_in;
                shadow_blank <= blank_in;
            end
            if (frame_wrap || en_rise) begin
                active_data  <= next_data;
                active_dp    <= next_dp;
                active_blank <= next_blank;
            end
        end
    end

    assign cur_nibble = active_data[{digit_idx, 2'b00} +: 4];

    hex_to_sseg u_hex_to_sseg (
        .nibble (cur_nibble),
        .seg    (cur_glyph)
    );

    // The first cycle of every slot keeps all anodes dark to avoid ghosting
    assign digit_on = en && (cnt != '0) && !active_blank[digit_idx];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            AN <= AN_OFF;
            s  <= SEG_OFF;
            DP <= 1'b1;
        end else begin
            AN <= digit_on ? anode_select_n(digit_idx) : AN_OFF;
            s  <= digit_on ? cur_glyph : SEG_OFF;
            DP <= digit_on ? ~active_dp[digit_idx] : 1'b1;
        end
    end

endmodule

// File: doc/sseg_scan_driver.md
SSEG_SCAN_DRIVER -- requirements
Module: sseg_scan_driver

Interface
REQ-001 Parameter: CLK_DIV, default 100000, clock cycles each digit stays active (minimum 2).
REQ-002 Parameter: CNT_W, default 17, width of the refresh counter; it SHALL satisfy 2^CNT_W >= CLK_DIV.
REQ-003 Port: clk, input, 1, the single system clock; every register uses its rising edge.
REQ-004 Port: reset_n, input, 1, asynchronous active-low reset.
REQ-005 Port: en, input, 1, scan enable; when low, the counter freezes and all anodes go off.
REQ-006 Port: load, input, 1, single-cycle strobe that captures data_in, dp_in and blank_in.
REQ-007 Port: data_in, input, 32, eight hex nibbles; nibble k (bits 4k+3..4k) goes to digit k.
REQ-008 Port: dp_in, input, 8, per-digit decimal point; 1 lights the point.
REQ-009 Port: blank_in, input, 8, per-digit blank; 1 turns the digit off.
REQ-010 Port: AN, output, 8, active-low anode selects; at most one bit is 0 at any time.
REQ-011 Port: s, output, 7, active-low segments {g,f,e,d,c,b,a}.
REQ-012 Port: DP, output, 1, active-low decimal point.
REQ-013 Port: digit_idx, output, 3, index of the digit currently being scanned.
REQ-014 Port: frame_done, output, 1, one-cycle pulse when digit 7's slot ends.

Function
REQ-015 A refresh counter SHALL count 0..CLK_DIV-1 and wrap; on wrap, digit_idx SHALL increment modulo 8 (7 -> 0).
REQ-016 When load=1, the block SHALL capture data_in/dp_in/blank_in into shadow registers at that clock edge.
REQ-017 Active display registers SHALL copy the shadow registers only when digit_idx wraps 7 -> 0, so a frame never shows mixed old and new data.
REQ-018 If load coincides with the 7 -> 0 wrap, the active registers SHALL receive the new load values at that same edge.
REQ-019 If load is asserted on consecutive cycles, the last one wins; no loss or error indication.
REQ-020 AN, s and DP SHALL be registered outputs; they reflect digit_idx and the active registers with exactly 1 cycle of latency.
REQ-021 AN[digit_idx] SHALL be 0 unless the digit is blanked or en=0; in those cases AN SHALL be 8'hFF.
REQ-022 s SHALL be the hex glyph for nibbles 0-F (A, b, C, d, E, F for 10-15), active-low.
REQ-023 DP SHALL be the inverse of the active dp bit for the current digit; DP=1 whenever that digit's anode is off.
REQ-024 While en=0, the counter and digit_idx SHALL hold, and load SHALL still update the shadow registers.
REQ-025 Active registers SHALL also update from shadow on the first cycle en goes 0 -> 1.
REQ-026 frame_done SHALL pulse for exactly one cycle, coincident with the 7 -> 0 wrap; it is never asserted while en=0.
REQ-027 Anode blanking between digits: for the first cycle of each slot (counter=0), AN SHALL be 8'hFF to prevent ghosting.

Reset
REQ-028 Asserting reset_n=0 SHALL immediately set: counter=0, digit_idx=0, AN=8'hFF, s=7'h7F, DP=1, frame_done=0, all shadow/active data=0, all blank bits=1.
REQ-029 After reset_n is released, the first digit-0 slot SHALL begin on the next edge with en=1; a reset mid-frame discards any pending shadow data.

Structure
REQ-030 A shared package SHALL hold the hex-to-7-segment glyph constants (16 x 7-bit, active-low) and the default CLK_DIV value.
REQ-031 Sub-module hex_to_sseg (4-bit in, 7-bit active-low out, combinational) SHALL perform glyph decoding; it is instantiated once.
REQ-032 No other hierarchy; the counter, index, shadow/active registers and output registers live in the top.

Verification
REQ-033 Reset check: assert reset_n=0 mid-scan -> AN=FF, s=7F, DP=1 asynchronously; after release with en=1, AN=FE appears at counter=1.
REQ-034 Full scan (CLK_DIV=4): load data_in=32'h76543210, blank=00, dp=01 -> AN walks FE, FD, FB ... 7F; s shows 0..7; DP=0 only on digit 0.
REQ-035 Tear-free update: load 32'hFFFFFFFF while digit_idx=3 -> digits 3-7 still show the old data; new data appears from the next digit 0.
REQ-036 Simultaneous load and wrap: load exactly at the 7 -> 0 edge -> digit 0 of the new frame shows the new nibble; frame_done pulses once.
REQ-037 Blank/enable: blank_in=8'hAA -> odd slots give AN=FF; en=0 for 10 cycles -> AN=FF, digit_idx frozen, then scan resumes at the same digit.
REQ-038 Glyph sweep: nibbles 0-F on digit 0 -> s matches the package table for all 16 values.
